// File: rtl/hash_req_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hash_req_arbiter_if                                                      |
// | Requester handshake and shared hash-unit bus for hash_req_arbiter.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface hash_req_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int VPN_W  = 45,
  parameter int HASH_W = 32
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*VPN_W-1:0]  req_vpn;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [NREQ*HASH_W-1:0] rsp_hash;
  logic [VPN_W-1:0]       hash_vpn;
  logic [HASH_W-1:0]      hash_out;

  // Environment side: requesters plus the hash unit.
  modport master (
    output req_valid, req_vpn, rsp_ready, hash_out,
    input  req_ready, rsp_valid, rsp_hash, hash_vpn
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_vpn, rsp_ready, hash_out,
    output req_ready, rsp_valid, rsp_hash, hash_vpn
  );
endinterface
`default_nettype wire

// File: rtl/hash_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hash_req_arbiter                                                         |
// | Round-robin sharing of one fixed-latency hash unit among NREQ requesters.|
// | Optional macro HASH_ARB_PERF_EN adds grant/conflict counters.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hash_req_arbiter #(
  parameter int NREQ     = 4,
  parameter int VPN_W    = 45,
  parameter int HASH_W   = 32,
  parameter int HASH_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  hash_req_arbiter_if.slave  bus
`ifdef HASH_ARB_PERF_EN
  ,
  output logic [31:0]        grant_cnt,
  output logic [31:0]        conflict_cnt
`endif
);

  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]        busy_q, busy_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [HASH_LAT-1:0]    tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]        tag_id_q [HASH_LAT];
  logic [ID_W-1:0]        tag_id_d [HASH_LAT];
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NREQ*HASH_W-1:0] rsp_hash_q, rsp_hash_d;

  logic [NREQ-1:0]        eligible;
  logic [NREQ-1:0]        grant;
  logic                   grant_any;
  logic [ID_W-1:0]        grant_id;
  logic [ID_W-1:0]        idx;
  logic [ID_W:0]          sum;
  logic [VPN_W-1:0]       hash_vpn_w;

  assign eligible = bus.req_valid & ~busy_q;

  // First eligible requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    sum       = '0;
    idx       = '0;
    for (int off = 0; off < NREQ; off++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(NREQ)) sum = sum - (ID_W+1)'(NREQ);
      idx = sum[ID_W-1:0];
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
    grant = grant_any ? (NREQ'(1) << grant_id) : '0;
  end

  always_comb begin
    hash_vpn_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) hash_vpn_w = bus.req_vpn[i*VPN_W +: VPN_W];
    end
  end

  always_comb begin
    busy_d   = (busy_q | grant) & ~(rsp_valid_q & bus.rsp_ready);
    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = (grant_id == ID_W'(NREQ-1)) ? '0 : grant_id + ID_W'(1);

    tag_vld_d[0] = grant_any;
    tag_id_d[0]  = grant_id;
    for (int s = 1; s < HASH_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end

    // A pending slot is never the capture target: busy blocks its re-grant.
    rsp_valid_d = rsp_valid_q & ~bus.rsp_ready;
    rsp_hash_d  = rsp_hash_q;
    if (tag_vld_q[HASH_LAT-1]) begin
      for (int k = 0; k < NREQ; k++) begin
        if (tag_id_q[HASH_LAT-1] == ID_W'(k)) begin
          rsp_valid_d[k]                  = 1'b1;
          rsp_hash_d[k*HASH_W +: HASH_W]  = bus.hash_out;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      rr_ptr_q    <= '0;
      tag_vld_q   <= '0;
      rsp_valid_q <= '0;
      rsp_hash_q  <= '0;
      for (int s = 0; s < HASH_LAT; s++) tag_id_q[s] <= '0;
    end else begin
      busy_q      <= busy_d;
      rr_ptr_q    <= rr_ptr_d;
      tag_vld_q   <= tag_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hash_q  <= rsp_hash_d;
      for (int s = 0; s < HASH_LAT; s++) tag_id_q[s] <= tag_id_d[s];
    end
  end

  assign bus.req_ready = grant;
  assign bus.hash_vpn  = hash_vpn_w;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hash  = rsp_hash_q;

`ifdef HASH_ARB_PERF_EN
  logic [31:0]   grant_cnt_q, grant_cnt_d;
  logic [31:0]   conflict_cnt_q, conflict_cnt_d;
  logic [ID_W:0] n_elig;

  always_comb begin
    n_elig = '0;
    for (int i = 0; i < NREQ; i++) n_elig = n_elig + (ID_W+1)'(eligible[i]);
    grant_cnt_d    = grant_cnt_q + {31'd0, grant_any};
    conflict_cnt_d = conflict_cnt_q + {31'd0, (n_elig > (ID_W+1)'(1))};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt_q    <= grant_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign grant_cnt    = grant_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hash_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hash_req_arbiter                                                      |
// | Directed and random stimulus against a queue-based reference model.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_hash_req_arbiter;
  localparam int NREQ     = 4;
  localparam int VPN_W    = 45;
  localparam int HASH_W   = 32;
  localparam int HASH_LAT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hash_req_arbiter_if #(.NREQ(NREQ), .VPN_W(VPN_W), .HASH_W(HASH_W)) bus ();

`ifdef HASH_ARB_PERF_EN
  logic [31:0] grant_cnt;
  logic [31:0] conflict_cnt;
`endif

  hash_req_arbiter #(
    .NREQ(NREQ), .VPN_W(VPN_W), .HASH_W(HASH_W), .HASH_LAT(HASH_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef HASH_ARB_PERF_EN
    ,
    .grant_cnt    (grant_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  function automatic logic [31:0] hfun(input logic [44:0] v);
    return v[31:0] ^ {19'b0, v[44:32]};
  endfunction

  // Shared hash unit stand-in, one register stage.
  always @(posedge clk) bus.hash_out <= hfun(bus.hash_vpn);

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per-requester flags plus an in-flight queue in grant order.
  typedef struct {
    int          id;
    logic [31:0] h;
    int          cnt;
  } fl_t;

  bit          m_busy [NREQ];
  bit          m_rv   [NREQ];
  logic [31:0] m_rh   [NREQ];
  int          m_rr;
  fl_t         m_q [$];
  logic [31:0] m_gcnt;
  logic [31:0] m_ccnt;

  always @(negedge clk) begin : model
    int              g;
    int              ne;
    int              ix;
    fl_t             e;
    logic [NREQ-1:0] exp_ready;
    logic [44:0]     exp_vpn;
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        m_busy[i] = 1'b0;
        m_rv[i]   = 1'b0;
        m_rh[i]   = '0;
      end
      m_rr   = 0;
      m_gcnt = '0;
      m_ccnt = '0;
      m_q.delete();
    end else begin
      foreach (m_q[i]) m_q[i].cnt--;
      while (m_q.size() > 0 && m_q[0].cnt == 0) begin
        e = m_q.pop_front();
        m_rv[e.id] = 1'b1;
        m_rh[e.id] = e.h;
      end
    end

    g  = -1;
    ne = 0;
    for (int i = 0; i < NREQ; i++) if (bus.req_valid[i] && !m_busy[i]) ne++;
    for (int off = 0; off < NREQ; off++) begin
      ix = (m_rr + off) % NREQ;
      if (g < 0 && bus.req_valid[ix] && !m_busy[ix]) g = ix;
    end
    exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
    exp_vpn   = (g >= 0) ? bus.req_vpn[g*VPN_W +: VPN_W] : '0;

    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    check("hash_vpn",  64'(bus.hash_vpn),  64'(exp_vpn));
    for (int i = 0; i < NREQ; i++) begin
      check($sformatf("rsp_valid[%0d]", i), 64'(bus.rsp_valid[i]), 64'(m_rv[i]));
      check($sformatf("rsp_hash[%0d]", i),  64'(bus.rsp_hash[i*HASH_W +: HASH_W]), 64'(m_rh[i]));
    end
`ifdef HASH_ARB_PERF_EN
    check("grant_cnt",    64'(grant_cnt),    64'(m_gcnt));
    check("conflict_cnt", 64'(conflict_cnt), 64'(m_ccnt));
`endif

    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_rv[i] && bus.rsp_ready[i]) begin
          m_rv[i]   = 1'b0;
          m_busy[i] = 1'b0;
        end
      end
      if (g >= 0) begin
        m_busy[g] = 1'b1;
        m_rr      = (g + 1) % NREQ;
        m_q.push_back('{id: g, h: hfun(exp_vpn), cnt: HASH_LAT + 1});
        m_gcnt    = m_gcnt + 32'd1;
      end
      if (ne >= 2) m_ccnt = m_ccnt + 32'd1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vpn(input int i, input logic [44:0] v);
    bus.req_vpn[i*VPN_W +: VPN_W] = v;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_vpn   = '0;
    bus.rsp_ready = '1;
    rst_n         = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_hash1", 64'(bus.rsp_hash[HASH_W +: HASH_W]), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();

    // Single request on requester 2.
    set_vpn(2, 45'h0_1234_5678);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("single_ready", 64'(bus.req_ready), 64'h4);
    check("single_vpn",   64'(bus.hash_vpn),  64'h0_1234_5678);
    cyc();
    bus.req_valid = '0;
    @(negedge clk);
    check("single_rv_early", 64'(bus.rsp_valid), 64'h0);
    cyc();
    @(negedge clk);
    check("single_rv",   64'(bus.rsp_valid), 64'h4);
    check("single_hash", 64'(bus.rsp_hash[2*HASH_W +: HASH_W]), 64'h1234_5678);
    cyc();

    // All four together from a fresh reset.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < NREQ; i++) set_vpn(i, {13'(i + 1), 32'hA5A5_0000 + 32'(i)});
    bus.req_valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) check("all4_ready", 64'(bus.req_ready), 64'(1 << c));
      if (c == 4) begin
        check("all4_idle_vpn",   64'(bus.hash_vpn),  64'd0);
        check("all4_idle_ready", 64'(bus.req_ready), 64'd0);
      end
      if (c >= 2) check("all4_rv", 64'(bus.rsp_valid), 64'(1 << (c - 2)));
      cyc();
      if (c < 4) bus.req_valid[c] = 1'b0;
    end
`ifdef HASH_ARB_PERF_EN
    @(negedge clk);
    check("perf_grant_cnt",    64'(grant_cnt),    64'd4);
    check("perf_conflict_cnt", 64'(conflict_cnt), 64'd3);
`endif
    cyc();

    // Backpressure on requester 1 with its request held.
    set_vpn(1, 45'h1_0000_00FF);
    bus.rsp_ready = 4'b1101;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    check("bp_grant", 64'(bus.req_ready), 64'h2);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      @(negedge clk);
      check("bp_no_regrant", 64'(bus.req_ready), 64'h0);
      check("bp_rv", 64'(bus.rsp_valid[1]), (k >= 2) ? 64'd1 : 64'd0);
      if (k >= 2) check("bp_hash", 64'(bus.rsp_hash[HASH_W +: HASH_W]), 64'h0000_00FE);
    end
    cyc();
    bus.rsp_ready = 4'hF;
    @(negedge clk);
    check("bp_accept_cycle_ready", 64'(bus.req_ready), 64'h0);
    cyc();
    @(negedge clk);
    check("bp_regrant", 64'(bus.req_ready), 64'h2);
    cyc();
    bus.req_valid = '0;
    repeat (4) cyc();

    // Wrap: move rr_ptr to 3, then 0 and 3 compete.
    bus.req_valid = 4'b0100;
    cyc();
    bus.req_valid = '0;
    repeat (4) cyc();
    bus.req_valid = 4'b1001;
    @(negedge clk);
    check("wrap_first", 64'(bus.req_ready), 64'h8);
    cyc();
    bus.req_valid = 4'b0001;
    @(negedge clk);
    check("wrap_second", 64'(bus.req_ready), 64'h1);
    cyc();
    bus.req_valid = '0;
    repeat (4) cyc();
    bus.req_valid = 4'b0110;
    @(negedge clk);
    check("wrap_ptr_is_1", 64'(bus.req_ready), 64'h2);
    cyc();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("wrap_then_2", 64'(bus.req_ready), 64'h4);
    cyc();
    bus.req_valid = '0;
    repeat (4) cyc();

    // Reset while a request to 0 is in flight.
    set_vpn(0, 45'h0_0BAD_F00D);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    check("rmf_grant", 64'(bus.req_ready), 64'h1);
    cyc();
    bus.req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rmf_rv_in_reset", 64'(bus.rsp_valid), 64'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rmf_no_ghost", 64'(bus.rsp_valid), 64'h0);
      cyc();
    end
    set_vpn(2, 45'h1F_0000_0010);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("rmf_next_grant", 64'(bus.req_ready), 64'h4);
    cyc();
    bus.req_valid = '0;
    cyc();
    @(negedge clk);
    check("rmf_next_rv",   64'(bus.rsp_valid), 64'h4);
    check("rmf_next_hash", 64'(bus.rsp_hash[2*HASH_W +: HASH_W]), 64'h0000_000F);
    cyc();

    // Random traffic; the model process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      bus.req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        bus.rsp_ready[i] = ($urandom_range(0, 3) != 0);
        set_vpn(i, {13'($urandom), 32'($urandom)});
      end
      cyc();
    end
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    repeat (8) cyc();
    @(negedge clk);
    check("drain_rv", 64'(bus.rsp_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
